// File: rtl/obstacle_pkg.sv
// Shared types and constants for the two-lane obstacle scheduler.
// The game state encoding is visible on the scheduler's state port.
package obstacle_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2,
        OVER = 2'd3
    } game_state_t;

    localparam int SPAWN_X_DEFAULT = 740;
    localparam int SCREEN_W        = 800;
    localparam int ROW_COUNT       = 4;

    localparam int X_W     = 10;
    localparam int ROW_W   = 2;
    localparam int TYPE_W  = 2;
    localparam int LEVEL_W = 3;
    localparam int DIST_W  = 16;

    // Bump the random row by one when it would line up with the other lane.
    function automatic logic [ROW_W-1:0] pick_row(input logic [ROW_W-1:0] rnd_row,
                                                  input logic [ROW_W-1:0] other_row);
        return (rnd_row == other_row) ? ROW_W'(rnd_row + 1'b1) : rnd_row;
    endfunction

endpackage

// File: rtl/obstacle_scheduler_step_timer.sv
// Step pulse generator: level-dependent period, tick counter, distance and level.
// The period shrinks by TICK_DEC per level down to a TICK_MIN floor.
module step_timer
    import obstacle_pkg::*;
#(
    parameter int TICK_BASE   = 1023,
    parameter int TICK_DEC    = 64,
    parameter int TICK_MIN    = 255,
    parameter int LEVEL_STEPS = 512,
    parameter int MAX_LEVEL   = 7
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run,
    input  logic               clear,
    input  logic               hold,
    output logic               step,
    output logic               step_due,
    output logic [LEVEL_W-1:0] level,
    output logic [DIST_W-1:0]  distance
);

    localparam int PER_W       = 11;
    localparam int LEVEL_SHIFT = $clog2(LEVEL_STEPS);

    logic [PER_W-1:0]   tick_cnt;
    logic [PER_W-1:0]   period;
    logic [PER_W-1:0]   dec;
    logic [DIST_W-1:0]  level_raw;
    logic [LEVEL_W-1:0] level_next;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        period = PER_W'(TICK_MIN);
        dec    = PER_W'(level) * PER_W'(TICK_DEC);
        if (({1'b0, dec} + 12'(TICK_MIN)) <= 12'(TICK_BASE))
            period = PER_W'(TICK_BASE) - dec;
    end

    always_comb begin
        level_raw  = distance >> LEVEL_SHIFT;
        level_next = level_raw[LEVEL_W-1:0];
        if (level_raw > DIST_W'(MAX_LEVEL))
            level_next = LEVEL_W'(MAX_LEVEL);
    end

    // A collision in the same cycle wins over the step.
    assign step     = run && !hold && (tick_cnt == period);
    assign step_due = run && (PER_W'(tick_cnt + 1'b1) == period);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
            distance <= '0;
            level    <= '0;
        end else if (clear) begin
            tick_cnt <= '0;
            distance <= '0;
            level    <= '0;
        end else begin
            if (run)
                tick_cnt <= (tick_cnt == period) ? '0 : PER_W'(tick_cnt + 1'b1);
            if (step && (distance != '1))
                distance <= distance + 1'b1;
            level <= level_next;
        end
    end

endmodule

// File: rtl/obstacle_scheduler.sv
// Game controller: IDLE/RUN/HIT/OVER state machine plus the two-lane respawn arbiter.
// Step timing, distance and level live in step_timer.
module obstacle_scheduler
    import obstacle_pkg::*;
#(
    parameter int TICK_BASE   = 1023,
    parameter int TICK_DEC    = 64,
    parameter int TICK_MIN    = 255,
    parameter int LEVEL_STEPS = 512,
    parameter int MAX_LEVEL   = 7,
    parameter int SPAWN_X     = SPAWN_X_DEFAULT,
    parameter int MIN_GAP     = 180,
    parameter int HIT_CYCLES  = 2047
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               collision,
    input  logic [1:0]         spawn_req,
    input  logic [X_W-1:0]     obs1_x,
    input  logic [X_W-1:0]     obs2_x,
    input  logic [3:0]         rnd,
    output logic               step,
    output logic [1:0]         spawn_gnt,
    output logic [ROW_W-1:0]   spawn_row,
    output logic [TYPE_W-1:0]  spawn_type,
    output logic [LEVEL_W-1:0] level,
    output logic [DIST_W-1:0]  distance,
    output logic [1:0]         state
);

    localparam int                HIT_W   = $clog2(HIT_CYCLES + 1);
    localparam logic [X_W-1:0]    LIMIT_X = X_W'(SPAWN_X - MIN_GAP);

    game_state_t      cur_state, next_state;
    logic [HIT_W-1:0] hit_cnt;
    logic             run, clear, step_due;

    logic [1:0]       gnt_q;
    logic [1:0]       elig;
    logic             gnt_lane;
    logic             grant_ok;
    logic             rr_ptr;
    logic [ROW_W-1:0] new_row;
    logic [ROW_W-1:0] last_row [2];

    assign run   = (cur_state == RUN);
    assign clear = (cur_state == IDLE) && start;
    assign state = cur_state;

    step_timer #(
        .TICK_BASE   (TICK_BASE),
        .TICK_DEC    (TICK_DEC),
        .TICK_MIN    (TICK_MIN),
        .LEVEL_STEPS (LEVEL_STEPS),
        .MAX_LEVEL   (MAX_LEVEL)
    ) u_step_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (run),
        .clear    (clear),
        .hold     (collision),
        .step     (step),
        .step_due (step_due),
        .level    (level),
        .distance (distance)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cur_state <= IDLE;
        else          cur_state <= next_state;
    end

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            IDLE:    if (start)            next_state = RUN;
            RUN:     if (collision)        next_state = HIT;
            HIT:     if (hit_cnt == '0)    next_state = OVER;
            OVER:    if (start)            next_state = IDLE;
            default:                       next_state = IDLE;
        endcase
    end

    // Loaded so that OVER follows exactly HIT_CYCLES cycles spent in HIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            hit_cnt <= '0;
        else if (run && collision)
            hit_cnt <= HIT_W'(HIT_CYCLES - 1);
        else if ((cur_state == HIT) && (hit_cnt != '0))
            hit_cnt <= hit_cnt - 1'b1;
    end

    // A lane whose partner is itself waiting at x==0 is off screen, so it never blocks.
    always_comb begin
        elig[0]  = spawn_req[0] && ((obs2_x <= LIMIT_X) || spawn_req[1]);
        elig[1]  = spawn_req[1] && ((obs1_x <= LIMIT_X) || spawn_req[0]);
        gnt_lane = 1'b0;
        case (elig)
            2'b11:   gnt_lane = rr_ptr;
            2'b10:   gnt_lane = 1'b1;
            default: gnt_lane = 1'b0;
        endcase
        // Holding off while a grant is out keeps a still-high request from being re-granted,
        // and skipping step_due keeps the grant out of the step cycle.
        grant_ok = run && !collision && !step_due && (gnt_q == 2'b00) && (elig != 2'b00);
        new_row  = pick_row(rnd[1:0], last_row[~gnt_lane]);
    end

    // NOTE: the two-entry last_row array is reset because its contents steer the first grants.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt_q       <= 2'b00;
            spawn_row   <= '0;
            spawn_type  <= '0;
            rr_ptr      <= 1'b0;
            last_row[0] <= ROW_W'(0);
            last_row[1] <= ROW_W'(1);
        end else begin
            gnt_q <= 2'b00;
            if (grant_ok) begin
                gnt_q              <= gnt_lane ? 2'b10 : 2'b01;
                spawn_row          <= new_row;
                spawn_type         <= rnd[3:2];
                last_row[gnt_lane] <= new_row;
                rr_ptr             <= ~gnt_lane;
            end
        end
    end

    assign spawn_gnt = (run && !collision) ? gnt_q : 2'b00;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Self-checking bench for obstacle_scheduler with shortened timing parameters.
`timescale 1ns/1ps
module tb_obstacle_scheduler;
    import obstacle_pkg::*;

    localparam int TB_BASE = 15, TB_DEC = 2, TB_MIN = 5, TB_LSTEPS = 4, TB_MAXL = 7;
    localparam int TB_SPX  = 740, TB_GAP = 180, TB_HIT = 8;

    logic        clk = 1'b0;
    logic        reset_n, start, collision;
    logic [1:0]  spawn_req;
    logic [9:0]  obs1_x, obs2_x;
    logic [3:0]  rnd;
    logic        step;
    logic [1:0]  spawn_gnt, spawn_row, spawn_type, state;
    logic [2:0]  level;
    logic [15:0] distance;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct { logic [1:0] gnt; logic [1:0] row; logic [1:0] typ; } grant_t;
    grant_t exp_q[$];

    typedef struct { int n_steps; int spacing; int lvl; } step_vec_t;
    step_vec_t vecs[8];

    obstacle_scheduler #(
        .TICK_BASE(TB_BASE), .TICK_DEC(TB_DEC), .TICK_MIN(TB_MIN), .LEVEL_STEPS(TB_LSTEPS),
        .MAX_LEVEL(TB_MAXL), .SPAWN_X(TB_SPX), .MIN_GAP(TB_GAP), .HIT_CYCLES(TB_HIT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .collision(collision),
        .spawn_req(spawn_req), .obs1_x(obs1_x), .obs2_x(obs2_x), .rnd(rnd),
        .step(step), .spawn_gnt(spawn_gnt), .spawn_row(spawn_row), .spawn_type(spawn_type),
        .level(level), .distance(distance), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_step(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (step !== 1'b1 && n < 100);
    endtask

    // Behaves like a mover: waits for its grant, then drops the request and reloads x.
    task automatic await_grant(input logic [1:0] lane_mask);
        int n = 0;
        while (spawn_gnt === 2'b00 && n < 40) begin
            tick();
            n++;
        end
        check("grant_latency_le2", (n >= 1 && n <= 2), 1'b1);
        tick();
        spawn_req = spawn_req & ~lane_mask;
        if (lane_mask[0]) obs1_x = 10'(TB_SPX);
        else              obs2_x = 10'(TB_SPX);
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        int seen = 0;
        repeat (cycles) begin
            tick();
            if (spawn_gnt !== 2'b00) seen++;
        end
        check(name, seen, 0);
    endtask

    // Scoreboard side: every grant the DUT issues is matched against the queue.
    initial begin
        grant_t exp_g;
        forever begin
            @(posedge clk);
            #1;
            if (reset_n === 1'b1 && spawn_gnt !== 2'b00) begin
                check("gnt_not_with_step", step, 1'b0);
                if (exp_q.size() == 0) begin
                    check("unexpected_gnt", spawn_gnt, 2'b00);
                end else begin
                    exp_g = exp_q.pop_front();
                    check("spawn_gnt", spawn_gnt, exp_g.gnt);
                    check("spawn_row", spawn_row, exp_g.row);
                    check("spawn_type", spawn_type, exp_g.typ);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int steps_done;
        logic [15:0] dist_before;

        vecs[0] = '{4, 16, 0};
        vecs[1] = '{4, 14, 1};
        vecs[2] = '{4, 12, 2};
        vecs[3] = '{4, 10, 3};
        vecs[4] = '{4,  8, 4};
        vecs[5] = '{4,  6, 5};
        vecs[6] = '{4,  6, 6};
        vecs[7] = '{8,  6, 7};

        reset_n = 1'b0; start = 1'b0; collision = 1'b0; spawn_req = 2'b00;
        obs1_x = 10'd0; obs2_x = 10'd0; rnd = 4'd0;
        tick();
        tick();
        #2 reset_n = 1'b1;
        tick();
        check("rst_state", state, 2'd0);
        check("rst_step", step, 1'b0);
        check("rst_gnt", spawn_gnt, 2'b00);
        check("rst_row", spawn_row, 2'd0);
        check("rst_type", spawn_type, 2'd0);
        check("rst_level", level, 3'd0);
        check("rst_distance", distance, 16'd0);

        // Step spacing per level; the first RUN cycle counts as cycle 1.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_entered", state, 2'd1);
        steps_done = 0;
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < vecs[r].n_steps; k++) begin
                wait_step(n);
                if (steps_done == 0) n = n + 1;
                check("step_spacing", n, vecs[r].spacing);
                check("distance_at_step", distance, steps_done);
                check("level_at_step", level, vecs[r].lvl);
                steps_done++;
            end
        end
        tick();
        tick();
        check("level_saturated", level, 3'd7);

        // Both lanes waiting, pointer at lane 0.
        spawn_req = 2'b11; obs1_x = 10'd0; obs2_x = 10'd0; rnd = 4'b0010;
        exp_q.push_back('{gnt: 2'b01, row: 2'd2, typ: 2'd0});
        await_grant(2'b01);
        expect_quiet("lane1_blocked_far", 20);
        obs1_x = 10'd561;
        expect_quiet("lane1_blocked_561", 10);
        rnd = 4'b0110;
        obs1_x = 10'd560;
        exp_q.push_back('{gnt: 2'b10, row: 2'd3, typ: 2'd1});
        await_grant(2'b10);

        // Row 3 against a partner last_row of 3 wraps to 0.
        obs2_x = 10'd300; rnd = 4'b1011; spawn_req = 2'b01;
        exp_q.push_back('{gnt: 2'b01, row: 2'd0, typ: 2'd2});
        await_grant(2'b01);

        // Pointer now favours lane 1.
        spawn_req = 2'b11; obs1_x = 10'd0; obs2_x = 10'd0; rnd = 4'b0100;
        exp_q.push_back('{gnt: 2'b10, row: 2'd1, typ: 2'd1});
        await_grant(2'b10);
        expect_quiet("lane0_blocked", 8);
        obs2_x = 10'd100;
        exp_q.push_back('{gnt: 2'b01, row: 2'd0, typ: 2'd1});
        await_grant(2'b01);
        tick();
        check("queue_drained", exp_q.size(), 0);

        // Collision lands on a step cycle: step suppressed, distance frozen.
        wait_step(n);
        repeat (5) tick();
        tick();
        check("step_due_before_hit", step, 1'b1);
        dist_before = distance;
        collision = 1'b1;
        #1;
        check("step_masked_by_hit", step, 1'b0);
        tick();
        collision = 1'b0;
        check("hit_entered", state, 2'd2);
        check("hit_no_distance", distance, dist_before);
        n = 0;
        while (state === 2'd2 && n < 100) begin
            tick();
            n++;
        end
        check("hit_cycles", n, TB_HIT);
        check("over_entered", state, 2'd3);
        check("over_no_step", step, 1'b0);
        check("over_distance", distance, dist_before);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("idle_after_over", state, 2'd0);
        check("idle_distance_kept", distance, dist_before);
        check("idle_level_kept", level, 3'd7);
        tick();
        check("idle_holds", state, 2'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rerun_state", state, 2'd1);
        check("rerun_distance", distance, 16'd0);
        check("rerun_level", level, 3'd0);

        // Asynchronous reset between edges.
        wait_step(n);
        check("rerun_first_step", n + 1, 16);
        wait_step(n);
        tick();
        check("pre_reset_distance", distance, 16'd2);
        #3 reset_n = 1'b0;
        #1;
        check("async_state", state, 2'd0);
        check("async_distance", distance, 16'd0);
        check("async_level", level, 3'd0);
        check("async_step", step, 1'b0);
        check("async_gnt", spawn_gnt, 2'b00);
        check("async_type", spawn_type, 2'd0);
        #2 reset_n = 1'b1;
        tick();
        check("post_reset_state", state, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
